// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - shared types and constants for the memory port arbiter
package mem_arb;

  // Arbiter mode: LOAD while the program is being uploaded, RUN afterwards
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Which requester is owed the read data returning next enabled cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int WAIT_W = 8;

  // Owner of a read issued this cycle; CPU and debug grants are one-hot so
  // at most one of the two inputs can be high.
  function automatic owner_e read_owner(input logic cpu_rd, input logic dbg_rd);
    owner_e o;
    o = OWN_NONE;
    if (cpu_rd) begin
      o = OWN_CPU;
    end else if (dbg_rd) begin
      o = OWN_DBG;
    end
    return o;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating debug wait counter with at-max flag
module starve_counter
  import mem_arb::*;
#(
  parameter int MAX_WAIT = 8  // legal range 1..255
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic at_max_o
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Count enabled cycles debug has been refused; any grant or idle cycle restarts
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req_i || gnt_i) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Counter register; reset wins over the enable so a held reset always clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (en_i) begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign at_max_o = (wait_cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - upload/CPU/debug arbiter for the single memory port
module mem_port_arbiter
  import mem_arb::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        upload_complete,
  input  logic        upload_req,
  input  logic [31:0] upload_addr,
  input  logic [7:0]  upload_wdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [31:0] mem_rdata,
  output logic        upload_gnt,
  output logic        cpu_gnt,
  output logic        dbg_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic        dbg_rvalid,
  output logic [31:0] rdata
);

  state_e      state_q, state_d;
  owner_e      rd_owner_q, rd_owner_d;
  logic [31:0] last_cpu_addr_q, last_cpu_addr_d;
  logic        dbg_at_max;
  logic        live;

  // Nothing is granted or returned on disabled cycles or while reset is held,
  // so a read outstanding when reset arrives never produces an rvalid.
  assign live = clk_enable & ~reset;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .en_i     (clk_enable),
    .req_i    (dbg_req),
    .gnt_i    (dbg_gnt),
    .at_max_o (dbg_at_max)
  );

  // Grant decision: upload owns the port in LOAD; in RUN a starved debug
  // request pre-empts the CPU, otherwise the CPU has priority.
  always_comb begin
    upload_gnt = 1'b0;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    if (live) begin
      if (state_q == LOAD) begin
        upload_gnt = upload_req;
      end else if (dbg_req && dbg_at_max) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  // Memory command mux; when idle the address parks on the last CPU address
  always_comb begin
    mem_addr  = last_cpu_addr_q;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_size  = SIZE_WORD;
    if (upload_gnt) begin
      mem_addr  = upload_addr;
      mem_wdata = {24'b0, upload_wdata};
      mem_we    = 1'b1;
      mem_size  = SIZE_BYTE;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      mem_size  = cpu_size;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      mem_size  = SIZE_WORD;
    end
  end

  // Next-state: mode follows upload_complete, read owner tracks this cycle's grant
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (upload_complete)  state_d = RUN;
      RUN:     if (!upload_complete) state_d = LOAD;
      default: state_d = LOAD;
    endcase
    rd_owner_d      = read_owner(cpu_gnt & ~cpu_we, dbg_gnt & ~dbg_we);
    last_cpu_addr_d = cpu_gnt ? cpu_addr : last_cpu_addr_q;
  end

  // Mode FSM and read-return pipeline, advancing only on enabled edges
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= LOAD;
      rd_owner_q      <= OWN_NONE;
      last_cpu_addr_q <= '0;
    end else if (clk_enable) begin
      state_q         <= state_d;
      rd_owner_q      <= rd_owner_d;
      last_cpu_addr_q <= last_cpu_addr_d;
    end
  end

  // Read return steered to the requester that issued the read one enabled cycle ago
  always_comb begin
    cpu_rvalid = live & (rd_owner_q == OWN_CPU);
    dbg_rvalid = live & (rd_owner_q == OWN_DBG);
    rdata      = (cpu_rvalid | dbg_rvalid) ? mem_rdata : '0;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between three requesters: the UART upload loader, the CPU pipeline (fetch at s2 or load/store at s2), and a UART debug-readback engine. It replaces the fixed mux in front of `memory`. It gives upload exclusive ownership until loading completes, then arbitrates between the CPU and debug with an anti-starvation counter. It routes read data back to the requester that issued the read, and produces the pipeline stall.

## Interface
- `MAX_WAIT`, 8: enabled cycles debug may wait before it pre-empts the CPU (range 1..255).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `clk_enable` in 1: ungated half-rate enable. All state advances only on edges where it is high.
- `upload_complete` in 1: level from the upload receiver; high = program loaded.
- `upload_req` in 1, `upload_addr` in 32, `upload_wdata` in 8: upload byte write request.
- `cpu_req` in 1, `cpu_we` in 1, `cpu_size` in 2, `cpu_addr` in 32, `cpu_wdata` in 32: CPU access request.
- `dbg_req` in 1, `dbg_we` in 1, `dbg_addr` in 32, `dbg_wdata` in 32: debug access request. Debug accesses are always word-sized.
- `mem_rdata` in 32: memory read data, valid one enabled cycle after the read.
- `upload_gnt`, `cpu_gnt`, `dbg_gnt` out 1 each: one-hot grant. All are 0 when `clk_enable` is low.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_we` out 1, `mem_size` out 2: memory command.
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`. Gates the pipeline `clk_enable`.
- `cpu_rvalid`, `dbg_rvalid` out 1 each; `rdata` out 32: read return.

## Operation
- FSM states are LOAD and RUN. Reset enters LOAD.
- LOAD → RUN on an enabled edge with `upload_complete=1`.
- RUN → LOAD on an enabled edge with `upload_complete=0`, which happens when the loader is re-armed.
- In LOAD:
  - Only upload can be granted. `upload_gnt = upload_req & clk_enable`.
  - The command is `{upload_addr, {24'b0, upload_wdata}, we=1, size=BYTE}`.
  - CPU and debug are never granted, even between upload bytes.
- In RUN, upload is ignored. Priority for the CPU/debug decision:
  - debug wins if `dbg_req` and `wait_cnt == MAX_WAIT`;
  - otherwise the CPU wins if `cpu_req`;
  - otherwise debug wins if `dbg_req`.
- Grants are combinational from the current requests and registered state. The memory samples the command on the same enabled edge.
- `wait_cnt` (8 bit) behaviour on each enabled edge:
  - increments when `dbg_req & ~dbg_gnt`;
  - saturates at `MAX_WAIT`;
  - clears to 0 on `dbg_gnt` or when `dbg_req=0`.
- When no grant is issued, the outputs are: `mem_we=0`, `mem_size=WORD`, `mem_addr` = last CPU address. This keeps fetch-address behaviour stable.
- Read tracking:
  - On an enabled edge with a granted read (`we=0`), `rd_owner` ← CPU or DBG. Otherwise `rd_owner` ← NONE.
  - In the following enabled cycle, `rdata = mem_rdata`, and the rvalid of that owner is high for exactly that enabled cycle.
  - Upload never creates a read.
- Requester rule: once a requester raises `req`, it holds req, address and data stable until granted. The arbiter does not check this.
- Reset values: state LOAD, `wait_cnt` 0, `rd_owner` NONE, all grants 0, `mem_we` 0, both rvalids 0, `rdata` 0, `cpu_stall` = `cpu_req` (combinational).
- Reset mid-access: an outstanding read is dropped and no rvalid is issued.

## Timing
- Grant latency is 0 cycles: grant is in the same enabled cycle as the request, if the request wins arbitration.
- Read data latency is 1 enabled cycle after the grant edge.
- Back-to-back reads by alternating owners are legal. `rd_owner` pipelines one deep.
- When `clk_enable` is low, all state holds, grants and `mem_we` are 0, and rvalids are 0.
- On the LOAD→RUN edge, no CPU or debug grant occurs in the transition cycle itself. The first RUN grant is at the next enabled cycle.
- Worst-case debug wait in RUN is `MAX_WAIT+1` enabled cycles. Worst-case CPU stall is 1 enabled cycle per debug pre-emption.

## Structure
- Package `mem_arb` holds:
  - `state_e` {LOAD, RUN};
  - `owner_e` {OWN_NONE, OWN_CPU, OWN_DBG};
  - size constants `SIZE_BYTE=2'b00`, `SIZE_HALF=2'b01`, `SIZE_WORD=2'b10`.
- One sub-module, `starve_counter`, implements the saturating `wait_cnt` and its `at_max` flag, parameterised by `MAX_WAIT`.

## Test plan
- Reset with `upload_complete=0`, `cpu_req=1`:
  - every enabled cycle gives `cpu_gnt=0` and `cpu_stall=1`;
  - `upload_req` with addr 0x10, data 0xA5 gives `mem_we=1`, `mem_size=BYTE`, `mem_wdata=0x000000A5`.
- Raise `upload_complete`, CPU reads 0x40 with `mem_rdata=0xDEADBEEF`:
  - `cpu_gnt` is issued at the first RUN enabled cycle;
  - `cpu_rvalid=1` with `rdata=0xDEADBEEF` exactly one enabled cycle later;
  - `dbg_rvalid=0`.
- `MAX_WAIT=3`, `cpu_req` and `dbg_req` held continuously: `dbg_gnt` occurs on the 4th enabled cycle, `cpu_stall=1` only that cycle, and `wait_cnt` returns to 0.
- Interleaved CPU read at 0x0 then debug read at 0x4 on consecutive enabled cycles: the rvalids arrive in order, each with its own data, never both high.
- Assert `reset` one cycle after a granted CPU read: no `cpu_rvalid`, and the state returns to LOAD.
- Drop `upload_complete` while in RUN: the next enabled edge enters LOAD, and CPU and debug grants stay 0 until `upload_complete` rises again.
